// File: rtl/iaaa_processor.sv
// IAAA: 16-bit two-cycle (FETCH/EXEC) register/accumulator processor with a unified
// 256x16 program/data memory. Every internal register and control line is a debug port.
module iaaa_processor #(
  parameter     MEM_FILE  = "program.hex",
  parameter int MEM_DEPTH = 256
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic [15:0] datain1,
  output logic [15:0] dataout1,
  output logic [15:0] instrout1,
  output logic [1:0]  memcontrol1,
  output logic [15:0] pc1,
  output logic [15:0] addr1,
  output logic [3:0]  ir_out,
  output logic [15:0] r1_out,
  output logic [15:0] r2_out,
  output logic [15:0] r3_out,
  output logic [15:0] r4_out,
  output logic [15:0] r5_out,
  output logic [15:0] r6_out,
  output logic [15:0] r7_out,
  output logic [15:0] r8_out,
  output logic [15:0] r9_out,
  output logic [15:0] r10_out,
  output logic [15:0] r11_out,
  output logic [15:0] r12_out,
  output logic [15:0] r13_out,
  output logic [15:0] r14_out,
  output logic [15:0] i_out,
  output logic [15:0] totr_out,
  output logic [4:0]  rg1_out,
  output logic [4:0]  rg2_out,
  output logic [4:0]  tr_out,
  output logic [15:0] abus_out,
  output logic [15:0] bbus_out,
  output logic [19:0] wrdec_out,
  output logic [18:0] rdec_out,
  output logic [15:0] ac_out,
  output logic [3:0]  ALUOp,
  output logic        pcd,
  output logic        Z,
  output logic        Y,
  output logic [5:0]  current_reg
);
  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [3:0] OpMov = 4'd1, OpAdd = 4'd2, OpSub = 4'd3, OpAnd = 4'd4, OpOr = 4'd5,
                         OpXor = 4'd6, OpInc = 4'd7, OpLdi = 4'd8, OpLoad = 4'd9,
                         OpStore = 4'd10, OpJmp = 4'd11, OpJz = 4'd12, OpJnz = 4'd13,
                         OpDec = 4'd14, OpHalt = 4'd15;

  localparam logic [3:0] AluPass = 4'd0, AluAdd = 4'd1, AluSub = 4'd2, AluAnd = 4'd3,
                         AluOr = 4'd4, AluXor = 4'd5, AluInc = 4'd6, AluDec = 4'd7;

  localparam logic [4:0] CodeAc = 5'd15, CodeTotr = 5'd16, CodePc = 5'd17, CodeI = 5'd18;

  typedef enum logic [1:0] {StFetch = 2'd0, StExec = 2'd1, StHalt = 2'd2} state_e;
  state_e state_q, state_d;

  logic [15:0] mem_q [MEM_DEPTH];
  logic [15:0] gpr_q [1:14];
  logic [15:0] pc_q, ac_q, i_q, totr_q, instr_q;
  logic [3:0]  ir_q;
  logic [4:0]  rg1_q, rg2_q;
  logic        z_q, y_q;

  logic [15:0] rfile [32];
  logic [15:0] abus, bbus, addr_raw, wr_data, alu_res;
  logic [3:0]  alu_op;
  logic        alu_cy, mem_we;

  // Unified read view of every register code; unused/reserved codes read as zero.
  always_comb begin
    for (int k = 0; k < 32; k++) rfile[k] = '0;
    for (int k = 1; k <= 14; k++) rfile[k] = gpr_q[k];
    rfile[15] = ac_q;
    rfile[16] = totr_q;
    rfile[17] = pc_q;
    rfile[18] = i_q;
  end

  assign abus    = (state_q == StExec) ? rfile[rg1_q] : '0;
  assign bbus    = (state_q == StExec) ? rfile[rg2_q] : '0;
  assign addr1   = {{(16 - AW){1'b0}}, addr_raw[AW-1:0]};
  assign datain1 = mem_q[addr1[AW-1:0]];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: state_d = StExec;
      StExec:  state_d = (ir_q == OpHalt) ? StHalt : StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Memory port and ALU operation selection.
  always_comb begin
    addr_raw    = pc_q;
    memcontrol1 = 2'b00;
    alu_op      = AluPass;
    mem_we      = 1'b0;
    dataout1    = '0;
    unique case (state_q)
      StFetch: memcontrol1 = 2'b01;
      StExec: begin
        case (ir_q)
          OpAdd: alu_op = AluAdd;
          OpSub: alu_op = AluSub;
          OpAnd: alu_op = AluAnd;
          OpOr:  alu_op = AluOr;
          OpXor: alu_op = AluXor;
          OpInc: alu_op = AluInc;
          OpDec: alu_op = AluDec;
          OpLdi, OpJmp, OpJz, OpJnz: memcontrol1 = 2'b01;
          OpLoad: begin
            addr_raw    = bbus;
            memcontrol1 = 2'b01;
          end
          OpStore: begin
            addr_raw    = bbus;
            memcontrol1 = 2'b10;
            dataout1    = abus;
            mem_we      = ~reset;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    unique case (alu_op)
      AluAdd:  {alu_cy, alu_res} = {1'b0, abus} + {1'b0, bbus};
      AluSub:  begin alu_res = abus - bbus; alu_cy = (abus < bbus); end
      AluAnd:  alu_res = abus & bbus;
      AluOr:   alu_res = abus | bbus;
      AluXor:  alu_res = abus ^ bbus;
      AluInc:  {alu_cy, alu_res} = {1'b0, abus} + 17'd1;
      AluDec:  begin alu_res = abus - 16'd1; alu_cy = (abus == '0); end
      default: alu_res = abus;
    endcase
  end

  // Destination select; a write to PC always wins over the increment.
  always_comb begin
    tr_out  = '0;
    wr_data = '0;
    pcd     = (state_q == StFetch);
    if (state_q == StExec) begin
      case (ir_q)
        OpMov:  begin tr_out = rg1_q; wr_data = bbus; end
        OpLdi:  begin tr_out = rg1_q; wr_data = datain1; pcd = 1'b1; end
        OpLoad: begin tr_out = rg1_q; wr_data = datain1; end
        OpJmp:  begin tr_out = CodePc; wr_data = datain1; end
        OpJz, OpJnz: begin
          if ((ir_q == OpJz) == z_q) begin
            tr_out  = CodePc;
            wr_data = datain1;
          end else begin
            pcd = 1'b1;
          end
        end
        default: begin
          if (alu_op != AluPass) begin
            tr_out  = CodeAc;
            wr_data = alu_res;
          end
        end
      endcase
      if (tr_out == CodePc) pcd = 1'b0;
    end
  end

  always_comb begin
    wrdec_out = '0;
    rdec_out  = '0;
    if (tr_out != 5'd0 && tr_out < 5'd20) wrdec_out[tr_out] = 1'b1;
    if (state_q == StExec) begin
      if (rg1_q < 5'd19) rdec_out[rg1_q] = 1'b1;
      if (rg2_q < 5'd19) rdec_out[rg2_q] = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int k = 1; k <= 14; k++) gpr_q[k] <= '0;
      pc_q    <= '0;
      ac_q    <= '0;
      i_q     <= '0;
      totr_q  <= '0;
      instr_q <= '0;
      ir_q    <= '0;
      rg1_q   <= '0;
      rg2_q   <= '0;
      z_q     <= 1'b0;
      y_q     <= 1'b0;
    end else begin
      if (state_q == StFetch) begin
        instr_q <= datain1;
        ir_q    <= datain1[15:12];
        rg1_q   <= datain1[11:7];
        rg2_q   <= datain1[6:2];
      end
      if (state_q == StExec && ir_q == OpLdi)  i_q    <= datain1;
      if (state_q == StExec && ir_q == OpLoad) totr_q <= datain1;
      if (tr_out >= 5'd1 && tr_out <= 5'd14) gpr_q[tr_out[3:0]] <= wr_data;
      if (tr_out == CodeAc)   ac_q   <= wr_data;
      if (tr_out == CodeTotr) totr_q <= wr_data;
      if (tr_out == CodeI)    i_q    <= wr_data;
      if (tr_out == CodePc)   pc_q   <= wr_data;
      else if (pcd)           pc_q   <= pc_q + 16'd1;
      if (alu_op != AluPass) begin
        z_q <= (alu_res == '0);
        y_q <= alu_cy;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (mem_we) mem_q[addr1[AW-1:0]] <= dataout1;
  end

  assign instrout1   = instr_q;
  assign pc1         = pc_q;
  assign ir_out      = ir_q;
  assign i_out       = i_q;
  assign totr_out    = totr_q;
  assign rg1_out     = rg1_q;
  assign rg2_out     = rg2_q;
  assign abus_out    = abus;
  assign bbus_out    = bbus;
  assign ac_out      = ac_q;
  assign ALUOp       = alu_op;
  assign Z           = z_q;
  assign Y           = y_q;
  assign current_reg = {4'b0000, state_q};
  assign r1_out      = gpr_q[1];
  assign r2_out      = gpr_q[2];
  assign r3_out      = gpr_q[3];
  assign r4_out      = gpr_q[4];
  assign r5_out      = gpr_q[5];
  assign r6_out      = gpr_q[6];
  assign r7_out      = gpr_q[7];
  assign r8_out      = gpr_q[8];
  assign r9_out      = gpr_q[9];
  assign r10_out     = gpr_q[10];
  assign r11_out     = gpr_q[11];
  assign r12_out     = gpr_q[12];
  assign r13_out     = gpr_q[13];
  assign r14_out     = gpr_q[14];

endmodule

// File: tb/tb_iaaa_processor.sv
// Bench for iaaa_processor: directed program walk-through followed by random programs
// executed in lock-step against an instruction-level reference model.
module tb_iaaa_processor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] datain1, dataout1, instrout1, pc1, addr1, i_out, totr_out;
  logic [15:0] abus_out, bbus_out, ac_out;
  logic [15:0] r_obs [1:14];
  logic [1:0]  memcontrol1;
  logic [3:0]  ir_out, alu_op;
  logic [4:0]  rg1_out, rg2_out, tr_out;
  logic [19:0] wrdec_out;
  logic [18:0] rdec_out;
  logic        pcd, z_flag, y_flag;
  logic [5:0]  current_reg;

  iaaa_processor #(.MEM_FILE(""), .MEM_DEPTH(256)) dut (
    .CLOCK_50(clk), .reset(rst), .datain1(datain1), .dataout1(dataout1),
    .instrout1(instrout1), .memcontrol1(memcontrol1), .pc1(pc1), .addr1(addr1),
    .ir_out(ir_out), .r1_out(r_obs[1]), .r2_out(r_obs[2]), .r3_out(r_obs[3]),
    .r4_out(r_obs[4]), .r5_out(r_obs[5]), .r6_out(r_obs[6]), .r7_out(r_obs[7]),
    .r8_out(r_obs[8]), .r9_out(r_obs[9]), .r10_out(r_obs[10]), .r11_out(r_obs[11]),
    .r12_out(r_obs[12]), .r13_out(r_obs[13]), .r14_out(r_obs[14]), .i_out(i_out),
    .totr_out(totr_out), .rg1_out(rg1_out), .rg2_out(rg2_out), .tr_out(tr_out),
    .abus_out(abus_out), .bbus_out(bbus_out), .wrdec_out(wrdec_out), .rdec_out(rdec_out),
    .ac_out(ac_out), .ALUOp(alu_op), .pcd(pcd), .Z(z_flag), .Y(y_flag),
    .current_reg(current_reg)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  logic [15:0] img   [256];
  logic [15:0] m_mem [256];
  logic [15:0] m_reg [32];  // indexed by register code; code 17 is the PC
  logic        m_z, m_y, m_halt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_image();
    for (int i = 0; i < 256; i++) begin
      dut.mem_q[i] <= img[i];
      m_mem[i] = img[i];
    end
  endtask

  // Reference model: one whole instruction per call, registers addressed by code.
  task automatic m_reset();
    for (int k = 0; k < 32; k++) m_reg[k] = '0;
    m_z = 1'b0;
    m_y = 1'b0;
    m_halt = 1'b0;
  endtask

  function automatic logic [15:0] m_rd(input logic [4:0] c);
    return (c >= 5'd1 && c <= 5'd18) ? m_reg[c] : 16'd0;
  endfunction

  task automatic m_wr(input logic [4:0] c, input logic [15:0] v);
    if (c >= 5'd1 && c <= 5'd18) m_reg[c] = v;
  endtask

  task automatic m_arith(input int s);
    logic [15:0] r;
    r = s[15:0];
    m_reg[15] = r;
    m_z = (r == 16'd0);
    m_y = (s < 0) || (s > 65535);
  endtask

  task automatic m_logic(input logic [15:0] v);
    m_reg[15] = v;
    m_z = (v == 16'd0);
    m_y = 1'b0;
  endtask

  task automatic m_step();
    logic [15:0] w, av, bv, v;
    logic [4:0]  a, b;
    logic [3:0]  op;
    logic        taken;
    if (m_halt) return;
    w = m_mem[m_reg[17][7:0]];
    m_reg[17] = m_reg[17] + 16'd1;
    op = w[15:12];
    a  = w[11:7];
    b  = w[6:2];
    av = m_rd(a);
    bv = m_rd(b);
    case (op)
      4'd1:  m_wr(a, bv);
      4'd2:  m_arith(int'(av) + int'(bv));
      4'd3:  m_arith(int'(av) - int'(bv));
      4'd4:  m_logic(av & bv);
      4'd5:  m_logic(av | bv);
      4'd6:  m_logic(av ^ bv);
      4'd7:  m_arith(int'(av) + 1);
      4'd14: m_arith(int'(av) - 1);
      4'd8: begin
        v = m_mem[m_reg[17][7:0]];
        m_reg[18] = v;
        m_reg[17] = m_reg[17] + 16'd1;
        m_wr(a, v);
      end
      4'd9: begin
        v = m_mem[bv[7:0]];
        m_reg[16] = v;
        m_wr(a, v);
      end
      4'd10: m_mem[bv[7:0]] = av;
      4'd11: m_reg[17] = m_mem[m_reg[17][7:0]];
      4'd12, 4'd13: begin
        taken = (op == 4'd12) ? m_z : !m_z;
        if (taken) m_reg[17] = m_mem[m_reg[17][7:0]];
        else       m_reg[17] = m_reg[17] + 16'd1;
      end
      4'd15: m_halt = 1'b1;
      default: ;
    endcase
  endtask

  task automatic compare_state();
    check("rnd_pc", pc1, m_reg[17]);
    check("rnd_ac", ac_out, m_reg[15]);
    check("rnd_totr", totr_out, m_reg[16]);
    check("rnd_i", i_out, m_reg[18]);
    check("rnd_z", z_flag, m_z);
    check("rnd_y", y_flag, m_y);
    check("rnd_state", current_reg, m_halt ? 32'd2 : 32'd0);
    for (int k = 1; k <= 14; k++) check("rnd_gpr", r_obs[k], m_reg[k]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) img[i] = 16'h0000;
    img[8'h00] = 16'h8080; img[8'h01] = 16'h0005;  // LDI R1,5
    img[8'h02] = 16'h8100; img[8'h03] = 16'h0003;  // LDI R2,3
    img[8'h04] = 16'h2088;                          // ADD R1,R2
    img[8'h05] = 16'h3084;                          // SUB R1,R1
    img[8'h06] = 16'h8200; img[8'h07] = 16'hFFFF;  // LDI R4,FFFF
    img[8'h08] = 16'h7200;                          // INC R4
    img[8'h09] = 16'h8100; img[8'h0A] = 16'h0020;  // LDI R2,20
    img[8'h0B] = 16'hA088;                          // STORE R1 -> [R2]
    img[8'h0C] = 16'h9188;                          // LOAD R3 <- [R2]
    img[8'h0D] = 16'hC000; img[8'h0E] = 16'h0010;  // JZ 10 (taken)
    img[8'h10] = 16'h2088;                          // ADD R1,R2
    img[8'h11] = 16'hC000; img[8'h12] = 16'h0030;  // JZ 30 (not taken)
    img[8'h13] = 16'hF000;                          // HALT
    load_image();
    #1;
    check("rst_pc", pc1, 0);
    check("rst_ac", ac_out, 0);
    check("rst_state", current_reg, 0);
    check("rst_r1", r_obs[1], 0);
    check("rst_zy", {z_flag, y_flag}, 0);
    check("rst_memctl", memcontrol1, 2'b01);
    release_reset();

    tick(); tick();
    check("ldi_r1", r_obs[1], 16'd5);
    check("ldi_pc", pc1, 16'd2);
    check("ldi_ir", ir_out, 4'b1000);
    check("ldi_i", i_out, 16'd5);
    tick(); tick();
    tick();
    check("add_aluop", alu_op, 4'd1);
    check("add_wrdec", wrdec_out, 20'h08000);
    check("add_rdec", rdec_out, 19'h00006);
    check("add_buses", {abus_out, bbus_out}, {16'd5, 16'd3});
    tick();
    check("add_ac", ac_out, 16'd8);
    check("add_zy", {z_flag, y_flag}, 2'b00);
    tick(); tick();
    check("sub_ac", ac_out, 16'd0);
    check("sub_zy", {z_flag, y_flag}, 2'b10);
    tick(); tick();
    tick(); tick();
    check("inc_ac", ac_out, 16'd0);
    check("inc_zy", {z_flag, y_flag}, 2'b11);
    tick(); tick();
    tick();
    check("st_memctl", memcontrol1, 2'b10);
    check("st_data", dataout1, 16'd5);
    check("st_addr", addr1, 16'h0020);
    tick();
    check("st_mem", dut.mem_q[8'h20], 16'd5);
    tick();
    check("ld_memctl", memcontrol1, 2'b01);
    tick();
    check("ld_r3", r_obs[3], 16'd5);
    check("ld_totr", totr_out, 16'd5);
    tick();
    check("jz_tr", tr_out, 5'd17);
    check("jz_wrdec", wrdec_out, 20'h20000);
    tick();
    check("jz_taken_pc", pc1, 16'h0010);
    tick(); tick();
    check("add2_ac", ac_out, 16'h0025);
    check("add2_z", z_flag, 1'b0);
    tick(); tick();
    check("jz_skip_pc", pc1, 16'h0013);
    tick(); tick();
    check("halt_state", current_reg, 6'd2);
    check("halt_pcd", pcd, 1'b0);
    check("halt_memctl", memcontrol1, 2'b00);
    repeat (3) tick();
    check("halt_hold_pc", pc1, 16'h0014);
    check("halt_hold_state", current_reg, 6'd2);

    rst = 1'b1;
    #1;
    check("rst2_pc", pc1, 0);
    check("rst2_ac", ac_out, 0);
    check("rst2_r3", r_obs[3], 0);
    check("rst2_totr", totr_out, 0);
    check("rst2_state", current_reg, 0);
    release_reset();
    tick(); tick();
    check("rel_r1", r_obs[1], 16'd5);
    tick();
    check("mid_exec", current_reg, 6'd1);
    rst = 1'b1;
    #1;
    check("abort_state", current_reg, 0);
    check("abort_pc", pc1, 0);
    check("abort_r1", r_obs[1], 0);
    tick();
    check("abort_r2", r_obs[2], 0);

    for (int run = 0; run < 8; run++) begin
      rst = 1'b1;
      #1;
      for (int i = 0; i < 256; i++) begin
        img[i] = 16'($urandom);
        if (img[i][15:12] == 4'hF) img[i][15:12] = 4'($urandom_range(0, 14));
      end
      load_image();
      m_reset();
      release_reset();
      for (int n = 0; n < 60; n++) begin
        tick(); tick();
        m_step();
        compare_state();
        if (m_halt) break;
      end
      for (int i = 0; i < 256; i++) check("rnd_mem", dut.mem_q[i], m_mem[i]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
